deconv1d: RTL and testbench



---
 rtl/deconv1d_pkg.sv | 23 ++
 rtl/deconv1d_acc_bank.sv | 37 +++
 rtl/deconv1d.sv | 121 ++++++++++++
 tb/tb_deconv1d.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/deconv1d_pkg.sv
// Shared types and helpers for the 1-D transposed convolution stage.
package deconv1d_pkg;

  typedef enum logic [1:0] {IDLE, MAC, EMIT, FLUSH} deconv_state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Drops the fractional bits of a full-width product; the caller keeps the low DATA_WIDTH bits.
  function automatic logic [63:0] prod_slice(input logic [63:0] prod, input int frac);
    return prod >> frac;
  endfunction

endpackage

// File: rtl/deconv1d_acc_bank.sv
// Partial-sum accumulators: M-lane indexed add during MAC, shift toward acc[0] on emit.
module deconv1d_acc_bank
  import deconv1d_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int FILTER_SIZE = 5,
  parameter int MAX_MULTS   = 2,
  parameter int PASS_W      = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  add_en,
  input  logic [PASS_W-1:0]                     pass,
  input  logic [MAX_MULTS-1:0][DATA_WIDTH-1:0]  lane_prod,
  input  logic                                  shift_en,
  output logic signed [DATA_WIDTH-1:0]          acc0
);

  logic signed [DATA_WIDTH-1:0] acc [FILTER_SIZE];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FILTER_SIZE; i++) acc[i] <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < FILTER_SIZE - 1; i++) acc[i] <= acc[i+1];
      acc[FILTER_SIZE-1] <= '0;
    end else if (add_en) begin
      // Lane j of pass p owns tap p*M+j; indices past K-1 never match and stay idle.
      for (int i = 0; i < FILTER_SIZE; i++)
        for (int j = 0; j < MAX_MULTS; j++)
          if (int'(pass) * MAX_MULTS + j == i) acc[i] <= acc[i] + $signed(lane_prod[j]);
    end
  end

  assign acc0 = acc[0];

endmodule

// File: rtl/deconv1d.sv
// Streaming stride-1 transposed convolution with time-multiplexed multipliers and tail flush.
module deconv1d
  import deconv1d_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int FILTER_SIZE = 5,
  parameter int MAX_MULTS   = 2,
  parameter int FRAC_WIDTH  = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  output logic                                   deconv_ready_in,
  input  logic                                   deconv_valid_in,
  input  logic [DATA_WIDTH-1:0]                  deconv_data_in,
  input  logic                                   deconv_last_in,
  input  logic [FILTER_SIZE-1:0][DATA_WIDTH-1:0] deconv_weights,
  input  logic [DATA_WIDTH-1:0]                  deconv_bias,
  input  logic                                   deconv_ready_out,
  output logic                                   deconv_valid_out,
  output logic [DATA_WIDTH-1:0]                  deconv_data_out,
  output logic                                   deconv_last_out
);

  localparam int PASSES  = (FILTER_SIZE + MAX_MULTS - 1) / MAX_MULTS;
  localparam int PASS_W  = (clog2(PASSES) < 1) ? 1 : clog2(PASSES);
  localparam int FLUSH_W = (clog2(FILTER_SIZE + 1) < 1) ? 1 : clog2(FILTER_SIZE + 1);

  deconv_state_t                state;
  logic [PASS_W-1:0]            pass;
  logic [FLUSH_W-1:0]           flush;
  logic signed [DATA_WIDTH-1:0] x_p0;
  logic                         last_p0;
  logic                         can_emit;
  logic signed [DATA_WIDTH-1:0] acc0;
  logic signed [DATA_WIDTH-1:0]   wsel [MAX_MULTS];
  logic signed [2*DATA_WIDTH-1:0] prod [MAX_MULTS];
  logic [MAX_MULTS-1:0][DATA_WIDTH-1:0] lane_prod;

  assign deconv_ready_in = (state == IDLE) && !rst;
  assign can_emit = ((state == EMIT) || (state == FLUSH)) &&
                    (!deconv_valid_out || deconv_ready_out);

  // MAC stage: each lane picks its tap weight for the current pass and multiplies by the latched sample.
  always_comb begin
    for (int j = 0; j < MAX_MULTS; j++) begin
      wsel[j] = '0;
      for (int i = 0; i < FILTER_SIZE; i++)
        if (int'(pass) * MAX_MULTS + j == i) wsel[j] = deconv_weights[i];
      prod[j]      = wsel[j] * x_p0;
      lane_prod[j] = DATA_WIDTH'(prod_slice(64'(prod[j]), FRAC_WIDTH));
    end
  end

  deconv1d_acc_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .FILTER_SIZE(FILTER_SIZE),
    .MAX_MULTS  (MAX_MULTS),
    .PASS_W     (PASS_W)
  ) u_acc_bank (
    .clk      (clk),
    .rst      (rst),
    .add_en   (state == MAC),
    .pass     (pass),
    .lane_prod(lane_prod),
    .shift_en (can_emit),
    .acc0     (acc0)
  );

  // Output stage: acc[0]+bias is registered and held until the downstream handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      pass             <= '0;
      flush            <= '0;
      last_p0          <= 1'b0;
      deconv_valid_out <= 1'b0;
      deconv_data_out  <= '0;
      deconv_last_out  <= 1'b0;
    end else begin
      if (deconv_valid_out && deconv_ready_out) deconv_valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (deconv_valid_in) begin
            x_p0    <= $signed(deconv_data_in);
            last_p0 <= deconv_last_in;
            pass    <= '0;
            state   <= MAC;
          end
        end
        MAC: begin
          if (pass == PASS_W'(PASSES - 1)) state <= EMIT;
          else pass <= pass + 1'b1;
        end
        EMIT: begin
          if (can_emit) begin
            deconv_data_out  <= acc0 + $signed(deconv_bias);
            deconv_valid_out <= 1'b1;
            deconv_last_out  <= last_p0 && (FILTER_SIZE == 1);
            if (last_p0 && (FILTER_SIZE > 1)) begin
              flush <= FLUSH_W'(FILTER_SIZE - 1);
              state <= FLUSH;
            end else begin
              state <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (can_emit) begin
            deconv_data_out  <= acc0 + $signed(deconv_bias);
            deconv_valid_out <= 1'b1;
            deconv_last_out  <= (flush == FLUSH_W'(1));
            flush            <= flush - 1'b1;
            if (flush == FLUSH_W'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deconv1d.sv
// Bench for deconv1d: fixed vectors, reset-in-flush sequence and randomized runs against a direct-sum model.
module tb_deconv1d;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, sel, valid_in, last_in, ready_out;
  logic [11:0]     data_in, bias;
  logic [4:0][11:0] wts;

  logic ra, rb, va, vb, la, lb;
  logic [11:0] da, db;
  logic ready_in_s, o_valid, o_last;
  logic [11:0] o_data;

  assign ready_in_s = sel ? rb : ra;
  assign o_valid    = sel ? vb : va;
  assign o_last     = sel ? lb : la;
  assign o_data     = sel ? db : da;

  deconv1d #(.DATA_WIDTH(12), .FILTER_SIZE(3), .MAX_MULTS(2), .FRAC_WIDTH(0)) dut_a (
    .clk(clk), .rst(rst), .deconv_ready_in(ra), .deconv_valid_in(valid_in && !sel),
    .deconv_data_in(data_in), .deconv_last_in(last_in), .deconv_weights(wts[2:0]),
    .deconv_bias(bias), .deconv_ready_out(ready_out), .deconv_valid_out(va),
    .deconv_data_out(da), .deconv_last_out(la));

  deconv1d #(.DATA_WIDTH(12), .FILTER_SIZE(5), .MAX_MULTS(5), .FRAC_WIDTH(0)) dut_b (
    .clk(clk), .rst(rst), .deconv_ready_in(rb), .deconv_valid_in(valid_in && sel),
    .deconv_data_in(data_in), .deconv_last_in(last_in), .deconv_weights(wts),
    .deconv_bias(bias), .deconv_ready_out(ready_out), .deconv_valid_out(vb),
    .deconv_data_out(db), .deconv_last_out(lb));

  typedef struct {
    int sel;
    int w[5];
    int bias;
    int n;
    int x[6];
    int nexp;
    int exp[10];
    int mode;
  } vec_t;

  vec_t tbl[5];
  int checks = 0;
  int fails  = 0;
  int sx[16];
  int sn;
  int ex[40];
  int en;
  int mode;
  int cur_w[5];
  int cur_bias;
  int in_cyc[16];
  int out_cyc[40];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int wrap12(input int v);
    logic signed [11:0] t;
    t = v[11:0];
    return int'(t);
  endfunction

  task automatic set_cfg(input int s);
    sel = s[0];
    for (int i = 0; i < 5; i++) wts[i] = 12'(cur_w[i]);
    bias = 12'(cur_bias);
  endtask

  // Direct transposed-convolution sum: y[n] = bias + sum_i x[i]*w[n-i], wrapped to 12 bits.
  task automatic build_expect(input int k);
    en = sn + k - 1;
    for (int n = 0; n < en; n++) begin
      int s;
      s = cur_bias;
      for (int i = 0; i < sn; i++)
        if (n - i >= 0 && n - i < k) s += sx[i] * cur_w[n-i];
      ex[n] = wrap12(s);
    end
  endtask

  task automatic run_seq(input string name);
    int idx, got, hold;
    bit in_fire, out_fire, prev_stall, seen;
    logic [11:0] pd;
    logic pl;
    idx = 0; got = 0; hold = 0;
    in_fire = 0; out_fire = 0; prev_stall = 0; seen = 0;
    pd = '0; pl = 1'b0;
    for (int c = 0; c < 3000 && got < en; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        chk({name, "_hold_valid"}, int'(o_valid), 1);
        chk({name, "_hold_data"}, int'(o_data), int'(pd));
        chk({name, "_hold_last"}, int'(o_last), int'(pl));
      end
      if (in_fire) begin
        in_cyc[idx] = c;
        idx++;
        chk({name, "_ready_in_busy"}, int'(ready_in_s), 0);
      end
      if (idx < sn) begin
        valid_in = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        data_in  = 12'(sx[idx]);
        last_in  = (idx == sn - 1);
      end else begin
        valid_in = 1'b0;
        last_in  = 1'b0;
      end
      if (o_valid) seen = 1;
      if (mode == 1) ready_out = ($urandom_range(0, 2) != 0);
      else if (mode == 2 && seen && hold < 5) begin
        ready_out = 1'b0;
        hold++;
      end else ready_out = 1'b1;
      in_fire    = valid_in && ready_in_s;
      out_fire   = o_valid && ready_out;
      prev_stall = o_valid && !ready_out;
      pd = o_data;
      pl = o_last;
      if (out_fire) begin
        chk($sformatf("%s_data%0d", name, got), wrap12(int'(o_data)), ex[got]);
        chk($sformatf("%s_last%0d", name, got), int'(o_last), int'(got == en - 1));
        out_cyc[got] = c;
        got++;
      end
    end
    if (got < en) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout outputs=%0d required=%0d", name, got, en);
    end
    @(negedge clk);
    valid_in  = 1'b0;
    ready_out = 1'b1;
    chk({name, "_no_extra"}, int'(o_valid), 0);
    chk({name, "_inputs"}, idx, sn);
  endtask

  task automatic send_one(input int x, input bit lst);
    bit done;
    done = 0;
    valid_in = 1'b1;
    data_in  = 12'(x);
    last_in  = lst;
    for (int c = 0; c < 200 && !done; c++) begin
      if (ready_in_s) done = 1;
      @(negedge clk);
    end
    valid_in = 1'b0;
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL send_timeout x=%0d", x);
    end
  endtask

  task automatic wait_out(input string name, input int req, input bit req_last);
    bit done;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (o_valid) begin
        chk({name, "_data"}, wrap12(int'(o_data)), req);
        chk({name, "_last"}, int'(o_last), int'(req_last));
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout no output required=%0d", name, req);
    end
  endtask

  initial begin
    tbl[0] = '{sel:0, w:'{1,2,3,0,0}, bias:0, n:2, x:'{1,1,0,0,0,0},
               nexp:4, exp:'{1,3,5,3,0,0,0,0,0,0}, mode:0};
    tbl[1] = '{sel:0, w:'{1,2,3,0,0}, bias:10, n:2, x:'{2,-1,0,0,0,0},
               nexp:4, exp:'{12,13,14,7,0,0,0,0,0,0}, mode:0};
    tbl[2] = '{sel:0, w:'{1,2,3,0,0}, bias:0, n:2, x:'{1,1,0,0,0,0},
               nexp:4, exp:'{1,3,5,3,0,0,0,0,0,0}, mode:2};
    tbl[3] = '{sel:1, w:'{1,1,1,1,1}, bias:0, n:5, x:'{1,1,1,1,1,0},
               nexp:9, exp:'{1,2,3,4,5,4,3,2,1,0}, mode:0};
    tbl[4] = '{sel:0, w:'{2047,0,0,0,0}, bias:0, n:1, x:'{2,0,0,0,0,0},
               nexp:3, exp:'{-2,0,0,0,0,0,0,0,0,0}, mode:0};

    rst = 1'b1; sel = 1'b0; valid_in = 1'b0; last_in = 1'b0; ready_out = 1'b1;
    data_in = '0; bias = '0; wts = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid_a", int'(va), 0);
    chk("rst_data_a", int'(da), 0);
    chk("rst_last_a", int'(la), 0);
    chk("rst_valid_b", int'(vb), 0);
    chk("rst_ready_in_a", int'(ra), 0);
    rst = 1'b0;
    #1;
    chk("idle_ready_in_a", int'(ra), 1);
    chk("idle_ready_in_b", int'(rb), 1);

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 5; i++) cur_w[i] = tbl[t].w[i];
      cur_bias = tbl[t].bias;
      set_cfg(tbl[t].sel);
      sn = tbl[t].n;
      for (int i = 0; i < sn; i++) sx[i] = tbl[t].x[i];
      en = tbl[t].nexp;
      for (int i = 0; i < en; i++) ex[i] = tbl[t].exp[i];
      mode = tbl[t].mode;
      run_seq($sformatf("vec%0d", t));
      if (t == 3)
        for (int i = 0; i < 5; i++)
          chk($sformatf("lat_b%0d", i), out_cyc[i] - in_cyc[i], 2);
    end

    // Reset while flushing a sequence whose partial sums are still non-zero.
    cur_w = '{1,2,3,0,0};
    cur_bias = 0;
    set_cfg(0);
    ready_out = 1'b1;
    @(negedge clk);
    send_one(3, 0);
    wait_out("rf_first", 3, 0);
    send_one(5, 1);
    wait_out("rf_second", 11, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rf_valid_cleared", int'(va), 0);
    chk("rf_data_cleared", int'(da), 0);
    chk("rf_last_cleared", int'(la), 0);
    rst = 1'b0;
    #1;
    chk("rf_ready_in", int'(ra), 1);
    @(negedge clk);
    send_one(1, 1);
    wait_out("rf_fresh0", 1, 0);
    wait_out("rf_fresh1", 2, 0);
    wait_out("rf_fresh2", 3, 1);
    chk("rf_no_extra", int'(va), 0);

    for (int r = 0; r < 24; r++) begin
      int s;
      int k;
      s = int'($urandom_range(0, 1));
      k = (s == 1) ? 5 : 3;
      for (int i = 0; i < 5; i++)
        cur_w[i] = (i < k) ? int'($urandom_range(0, 4095)) - 2048 : 0;
      cur_bias = int'($urandom_range(0, 4095)) - 2048;
      set_cfg(s);
      sn = int'($urandom_range(1, 6));
      for (int i = 0; i < sn; i++) sx[i] = int'($urandom_range(0, 4095)) - 2048;
      build_expect(k);
      mode = 1;
      run_seq($sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
